// File: rtl/data_to_segments.sv
// rtl/data_to_segments.sv - binary value to multi-digit active-low 7-segment display converter
// Conversion uses serial double-dabble: one Data bit per SHIFT cycle, then a single UPDATE cycle.
module data_to_segments #(
    parameter int Size   = 5,
    parameter     Signed = "Yes",
    parameter int Digits = 2
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic [Size-1:0]       Data,
    output logic [Digits*7-1:0]   Segments,
    output logic [6:0]            SignSeg,
    output logic                  Busy,
    output logic                  Overflow
);

    localparam bit   IsSigned  = (Signed == "Yes");
    localparam int   BW        = 4 * Digits;
    localparam int   CW        = $clog2(Size + 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [Size-1:0]      last_q, last_d;
    logic                 primed_q, primed_d;
    logic [Size-1:0]      mag_q, mag_d;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
    logic [Digits*7-1:0]  seg_q, seg_d;
    logic [6:0]           sign_q, sign_d;
    logic                 overflow_q, overflow_d;

    logic                 neg_in;
    logic [Size-1:0]      mag_in;
    logic [BW-1:0]        bcd_adj;
    logic [Digits*7-1:0]  seg_disp;
    logic [3:0]           nib;
    logic                 lead;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'b1000000;
            4'd1:    digit_seg = 7'b1111001;
            4'd2:    digit_seg = 7'b0100100;
            4'd3:    digit_seg = 7'b0110000;
            4'd4:    digit_seg = 7'b0011001;
            4'd5:    digit_seg = 7'b0010010;
            4'd6:    digit_seg = 7'b0000010;
            4'd7:    digit_seg = 7'b1111000;
            4'd8:    digit_seg = 7'b0000000;
            4'd9:    digit_seg = 7'b0010000;
            default: digit_seg = SEG_BLANK;
        endcase
    endfunction

    // Negating the most negative value wraps to 2^(Size-1), which is the correct magnitude unsigned.
    assign neg_in = IsSigned && Data[Size-1];
    assign mag_in = neg_in ? (~Data + Size'(1)) : Data;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < Digits; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Blank every digit above the most significant non-zero one; units always shown.
    always_comb begin
        seg_disp = '0;
        lead     = 1'b1;
        nib      = '0;
        for (int i = Digits - 1; i >= 0; i--) begin
            nib = bcd_q[4*i +: 4];
            if (lead && (nib == 4'd0) && (i != 0)) begin
                seg_disp[7*i +: 7] = SEG_BLANK;
            end else begin
                lead               = 1'b0;
                seg_disp[7*i +: 7] = digit_seg(nib);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        primed_d   = primed_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        seg_d      = seg_q;
        sign_d     = sign_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if ((Data != last_q) || !primed_q) begin
                    last_d   = Data;
                    primed_d = 1'b1;
                    mag_d    = mag_in;
                    neg_d    = neg_in;
                    bcd_d    = '0;
                    cnt_d    = CW'(Size);
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, mag_d} = {bcd_adj[BW-2:0], mag_q, 1'b0};
                ovf_d          = ovf_q | bcd_adj[BW-1];
                cnt_d          = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                overflow_d = ovf_q;
                if (ovf_q) begin
                    seg_d  = {Digits{SEG_MINUS}};
                    sign_d = SEG_BLANK;
                end else begin
                    seg_d  = seg_disp;
                    sign_d = neg_q ? SEG_MINUS : SEG_BLANK;
                end
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            last_q     <= '0;
            primed_q   <= 1'b0;
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            seg_q      <= '1;
            sign_q     <= SEG_BLANK;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            primed_q   <= primed_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            seg_q      <= seg_d;
            sign_q     <= sign_d;
            overflow_q <= overflow_d;
        end
    end

    assign Segments = seg_q;
    assign SignSeg  = sign_q;
    assign Busy     = busy_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_data_to_segments.sv
// tb/tb_data_to_segments.sv - self-checking bench for data_to_segments
`timescale 1ns/1ps
module tb_data_to_segments;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  data = '0;
    logic [4:0]  data_u = '0;
    logic [13:0] seg;
    logic [6:0]  sseg;
    logic        busy, ovf;
    logic [13:0] seg_u;
    logic [6:0]  sseg_u;
    logic        busy_u, ovf_u;
    logic [6:0]  seg_u1;
    logic [6:0]  sseg_u1;
    logic        busy_u1, ovf_u1;

    int          total = 0;
    int          bad = 0;
    int          last_main = -1;
    logic [13:0] prev_seg = 14'h3FFF;
    logic [6:0]  prev_sign = BLANK;

    always #5 clk = ~clk;

    data_to_segments #(.Size(5), .Signed("Yes"), .Digits(2)) dut (
        .Clock(clk), .nReset(rst_n), .Data(data),
        .Segments(seg), .SignSeg(sseg), .Busy(busy), .Overflow(ovf)
    );

    data_to_segments #(.Size(5), .Signed("No"), .Digits(2)) dut_u (
        .Clock(clk), .nReset(rst_n), .Data(data_u),
        .Segments(seg_u), .SignSeg(sseg_u), .Busy(busy_u), .Overflow(ovf_u)
    );

    data_to_segments #(.Size(5), .Signed("No"), .Digits(1)) dut_u1 (
        .Clock(clk), .nReset(rst_n), .Data(data_u),
        .Segments(seg_u1), .SignSeg(sseg_u1), .Busy(busy_u1), .Overflow(ovf_u1)
    );

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: enc = 7'b1000000;
            1: enc = 7'b1111001;
            2: enc = 7'b0100100;
            3: enc = 7'b0110000;
            4: enc = 7'b0011001;
            5: enc = 7'b0010010;
            6: enc = 7'b0000010;
            7: enc = 7'b1111000;
            8: enc = 7'b0000000;
            9: enc = 7'b0010000;
            default: enc = BLANK;
        endcase
    endfunction

    // Reference: decimal arithmetic on the integer value of a 5-bit input.
    function automatic void model(input logic [4:0] d, input bit sgn, input int ndig,
                                  output logic [13:0] eseg, output logic [6:0] esign,
                                  output logic eovf);
        int  v;
        int  p;
        bit  neg;
        v     = int'(d);
        neg   = 1'b0;
        if (sgn && v >= 16) begin
            neg = 1'b1;
            v   = 32 - v;
        end
        eseg  = '0;
        eovf  = 1'b0;
        esign = BLANK;
        if (v > 10**ndig - 1) begin
            eovf = 1'b1;
            for (int i = 0; i < ndig; i++) eseg[7*i +: 7] = MINUS;
        end else begin
            if (neg) esign = MINUS;
            p = 1;
            for (int i = 0; i < ndig; i++) begin
                if (i > 0 && v < p) eseg[7*i +: 7] = BLANK;
                else                eseg[7*i +: 7] = enc((v / p) % 10);
                p = p * 10;
            end
        end
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        data   = 5'd0;
        data_u = 5'd0;
        repeat (2) @(negedge clk);
        total++;
        if (seg !== 14'h3FFF || sseg !== BLANK) begin
            bad++; $display("FAIL reset_main_seg seg=%b sign=%b exp seg=%b sign=%b", seg, sseg, 14'h3FFF, BLANK);
        end
        total++;
        if (busy !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL reset_main_flags busy=%b ovf=%b exp 0 0", busy, ovf);
        end
        total++;
        if (seg_u !== 14'h3FFF || seg_u1 !== BLANK || busy_u !== 1'b0 || busy_u1 !== 1'b0 || ovf_u1 !== 1'b0) begin
            bad++; $display("FAIL reset_unsigned seg_u=%b seg_u1=%b busy=%b/%b ovf_u1=%b exp all blank, 0", seg_u, seg_u1, busy_u, busy_u1, ovf_u1);
        end
    endtask

    task automatic test_first_conversion();
        logic [13:0] es;
        logic [6:0]  ess;
        logic        eo;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b1 || seg !== 14'h3FFF || sseg !== BLANK) begin
                bad++; $display("FAIL first_conv_busy cycle=%0d busy=%b seg=%b exp busy=1 seg=all ones", k, busy, seg);
            end
        end
        @(negedge clk);
        model(5'd0, 1'b1, 2, es, ess, eo);
        total++;
        if (busy !== 1'b0 || seg !== es || seg !== {BLANK, 7'b1000000} || sseg !== BLANK || ovf !== 1'b0) begin
            bad++; $display("FAIL first_conv_result busy=%b seg=%b sign=%b ovf=%b exp busy=0 seg=%b sign=%b ovf=0", busy, seg, sseg, ovf, es, BLANK);
        end
        last_main = 0;
        prev_seg  = es;
        prev_sign = ess;
    endtask

    task automatic run_main(input logic [4:0] v, input string tag);
        logic [13:0] es;
        logic [6:0]  ess;
        logic        eo;
        @(negedge clk);
        data = v;
        if (int'(v) != last_main) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                total++;
                if (busy !== 1'b1 || seg !== prev_seg || sseg !== prev_sign) begin
                    bad++; $display("FAIL %s_busy cycle=%0d busy=%b seg=%b exp busy=1 seg=%b", tag, k, busy, seg, prev_seg);
                end
            end
            @(negedge clk);
            model(v, 1'b1, 2, es, ess, eo);
            total++;
            if (busy !== 1'b0 || seg !== es || sseg !== ess || ovf !== eo) begin
                bad++; $display("FAIL %s_result data=%b busy=%b seg=%b sign=%b ovf=%b exp busy=0 seg=%b sign=%b ovf=%b", tag, v, busy, seg, sseg, ovf, es, ess, eo);
            end
            last_main = int'(v);
            prev_seg  = es;
            prev_sign = ess;
        end else begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                total++;
                if (busy !== 1'b0 || seg !== prev_seg || sseg !== prev_sign) begin
                    bad++; $display("FAIL %s_static cycle=%0d busy=%b seg=%b exp busy=0 seg=%b", tag, k, busy, seg, prev_seg);
                end
            end
        end
    endtask

    task automatic test_directed();
        run_main(5'b01011, "d11");
        total++;
        if (seg !== {7'b1111001, 7'b1111001} || sseg !== BLANK || ovf !== 1'b0) begin
            bad++; $display("FAIL lit_11 seg=%b sign=%b ovf=%b exp seg=%b sign=%b ovf=0", seg, sseg, ovf, {7'b1111001, 7'b1111001}, BLANK);
        end
        run_main(5'b10000, "dm16");
        total++;
        if (seg !== {7'b1111001, 7'b0000010} || sseg !== MINUS) begin
            bad++; $display("FAIL lit_m16 seg=%b sign=%b exp seg=%b sign=%b", seg, sseg, {7'b1111001, 7'b0000010}, MINUS);
        end
        run_main(5'b11111, "dm1");
        total++;
        if (seg !== {BLANK, 7'b1111001} || sseg !== MINUS) begin
            bad++; $display("FAIL lit_m1 seg=%b sign=%b exp seg=%b sign=%b", seg, sseg, {BLANK, 7'b1111001}, MINUS);
        end
        run_main(5'd15, "d15");
        run_main(5'd10, "d10");
        run_main(5'd9,  "d9");
        run_main(5'd9,  "d9_again");
        run_main(5'd0,  "d0");
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run_main(5'($urandom_range(0, 31)), "rand");
        end
    endtask

    task automatic test_change_mid_conversion();
        logic [13:0] e3, e7;
        logic [6:0]  s3, s7;
        logic        o3, o7;
        if (last_main == 3) run_main(5'd0, "pre");
        model(5'd3, 1'b1, 2, e3, s3, o3);
        model(5'd7, 1'b1, 2, e7, s7, o7);
        @(negedge clk);
        data = 5'd3;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        data = 5'd7;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0 || seg !== e3 || sseg !== s3) begin
            bad++; $display("FAIL mid_first_result busy=%b seg=%b exp busy=0 seg=%b", busy, seg, e3);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL mid_restart busy=%b exp 1", busy);
        end
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b1 || seg !== e3) begin
            bad++; $display("FAIL mid_second_busy busy=%b seg=%b exp busy=1 seg=%b", busy, seg, e3);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || seg !== e7 || sseg !== s7) begin
            bad++; $display("FAIL mid_second_result busy=%b seg=%b exp busy=0 seg=%b", busy, seg, e7);
        end
        last_main = 7;
        prev_seg  = e7;
        prev_sign = s7;
    endtask

    task automatic test_unsigned();
        logic [4:0]  vals [8];
        logic [13:0] es, es1;
        logic [6:0]  ess, ess1;
        logic        eo, eo1;
        vals = '{5'd31, 5'd9, 5'd10, 5'd0, 5'd25,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            data_u = vals[n];
            repeat (8) @(negedge clk);
            model(vals[n], 1'b0, 2, es, ess, eo);
            model(vals[n], 1'b0, 1, es1, ess1, eo1);
            total++;
            if (busy_u !== 1'b0 || seg_u !== es || sseg_u !== ess || ovf_u !== eo) begin
                bad++; $display("FAIL uns2_%0d data=%0d seg=%b sign=%b ovf=%b exp seg=%b sign=%b ovf=%b", n, vals[n], seg_u, sseg_u, ovf_u, es, ess, eo);
            end
            total++;
            if (busy_u1 !== 1'b0 || seg_u1 !== es1[6:0] || sseg_u1 !== ess1 || ovf_u1 !== eo1) begin
                bad++; $display("FAIL uns1_%0d data=%0d seg=%b sign=%b ovf=%b exp seg=%b sign=%b ovf=%b", n, vals[n], seg_u1, sseg_u1, ovf_u1, es1[6:0], ess1, eo1);
            end
            if (n == 0) begin
                total++;
                if (seg_u !== {7'b0110000, 7'b1111001} || seg_u1 !== 7'b0111111 || ovf_u1 !== 1'b1 || sseg_u1 !== BLANK) begin
                    bad++; $display("FAIL lit_uns31 seg_u=%b seg_u1=%b ovf_u1=%b sign_u1=%b exp %b %b 1 %b", seg_u, seg_u1, ovf_u1, sseg_u1, {7'b0110000, 7'b1111001}, 7'b0111111, BLANK);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [4:0]  v;
        logic [13:0] es;
        logic [6:0]  ess;
        logic        eo;
        v = (last_main == 27) ? 5'd12 : 5'd27;
        @(negedge clk);
        data = v;
        @(posedge clk);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (seg !== 14'h3FFF || sseg !== BLANK || busy !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL abort_async seg=%b sign=%b busy=%b ovf=%b exp all ones, blank, 0, 0", seg, sseg, busy, ovf);
        end
        total++;
        if (seg_u !== 14'h3FFF || seg_u1 !== BLANK) begin
            bad++; $display("FAIL abort_async_uns seg_u=%b seg_u1=%b exp all ones", seg_u, seg_u1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b1 || seg !== 14'h3FFF) begin
                bad++; $display("FAIL abort_reconv_busy cycle=%0d busy=%b seg=%b exp busy=1 seg=all ones", k, busy, seg);
            end
        end
        @(negedge clk);
        model(v, 1'b1, 2, es, ess, eo);
        total++;
        if (busy !== 1'b0 || seg !== es || sseg !== ess || ovf !== eo) begin
            bad++; $display("FAIL abort_reconv_result busy=%b seg=%b sign=%b exp busy=0 seg=%b sign=%b", busy, seg, sseg, es, ess);
        end
        last_main = int'(v);
        prev_seg  = es;
        prev_sign = ess;
        run_main(v, "post_abort_static");
    endtask

    initial begin
        test_reset();
        test_first_conversion();
        test_directed();
        test_random();
        test_change_mid_conversion();
        test_unsigned();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
